// File: rtl/torso_pkg.sv
// torso_pkg: definitions shared by the slide sequencer and its fetch unit.
//   - seq_state_e : sequencer FSM states (IDLE / FETCH / READY)
//   - DEF_COORD_W : default coordinate word width
//   - SLOT_*      : capture order of the four random words
package torso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2
    } seq_state_e;

    localparam int DEF_COORD_W = 10;

    localparam logic [1:0] SLOT_XA = 2'd0;
    localparam logic [1:0] SLOT_YA = 2'd1;
    localparam logic [1:0] SLOT_XB = 2'd2;
    localparam logic [1:0] SLOT_YB = 2'd3;

endpackage

// File: rtl/rect_fetch.sv
// rect_fetch: fetches four random words over a req/ack handshake and orders
// them into a shadow rectangle (x0<=x1, y0<=y1).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         begin a new fetch (word index restarts at 0)
//   rnd_req_o       request held high until the 4th ack is sampled
//   rnd_ack_i       rnd_data_i valid this cycle
//   rnd_data_i      random coordinate word
//   done_o          combinational: the 4th word is captured on this edge
//   sx0_o..sy1_o    ordered shadow rectangle
module rect_fetch
    import torso_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               rnd_req_o,
    input  logic               rnd_ack_i,
    input  logic [COORD_W-1:0] rnd_data_i,
    output logic               done_o,
    output logic [COORD_W-1:0] sx0_o,
    output logic [COORD_W-1:0] sy0_o,
    output logic [COORD_W-1:0] sx1_o,
    output logic [COORD_W-1:0] sy1_o
);

    logic               active_q, active_d;
    logic [1:0]         idx_q, idx_d;
    logic [COORD_W-1:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d;
    logic [COORD_W-1:0] sx0_q, sx0_d, sy0_q, sy0_d, sx1_q, sx1_d, sy1_q, sy1_d;
    logic               cap;

    assign cap    = active_q & rnd_ack_i;
    assign done_o = cap & (idx_q == SLOT_YB);

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        xa_d     = xa_q;
        ya_d     = ya_q;
        xb_d     = xb_q;
        sx0_d    = sx0_q;
        sy0_d    = sy0_q;
        sx1_d    = sx1_q;
        sy1_d    = sy1_q;
        if (start_i) begin
            active_d = 1'b1;
            idx_d    = SLOT_XA;
        end else if (cap) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                SLOT_XA: xa_d = rnd_data_i;
                SLOT_YA: ya_d = rnd_data_i;
                SLOT_XB: xb_d = rnd_data_i;
                default: begin
                    // last word (yb) is still on the bus: order straight from it
                    active_d = 1'b0;
                    sx0_d    = (xa_q < xb_q) ? xa_q : xb_q;
                    sx1_d    = (xa_q < xb_q) ? xb_q : xa_q;
                    sy0_d    = (ya_q < rnd_data_i) ? ya_q : rnd_data_i;
                    sy1_d    = (ya_q < rnd_data_i) ? rnd_data_i : ya_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= SLOT_XA;
            xa_q     <= '0;
            ya_q     <= '0;
            xb_q     <= '0;
            sx0_q    <= '0;
            sy0_q    <= '0;
            sx1_q    <= '0;
            sy1_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            xa_q     <= xa_d;
            ya_q     <= ya_d;
            xb_q     <= xb_d;
            sx0_q    <= sx0_d;
            sy0_q    <= sy0_d;
            sx1_q    <= sx1_d;
            sy1_q    <= sy1_d;
        end
    end

    assign rnd_req_o = active_q;
    assign sx0_o     = sx0_q;
    assign sy0_o     = sy0_q;
    assign sx1_o     = sx1_q;
    assign sy1_o     = sy1_q;

endmodule

// File: rtl/slide_sequencer.sv
// slide_sequencer: per-second slide controller. Fetches a random shadow
// rectangle on the second pre-warning, commits it on the second boundary,
// counts slides and gates a beep tone for TONE_FRAMES frames per commit.
// Optional feature macro: SLIDE_SEQ_TONE_EN (undefined -> tone_en tied 0).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   gates sec_pre / sec_tick
//   frame_tick               frame-end pulse (tone countdown)
//   sec_pre, sec_tick        pre-warning and boundary pulses
//   rnd_req/rnd_ack/rnd_data random source handshake
//   rect_x0..rect_y1         active rectangle
//   tone_en                  beep gate
//   slide_cnt                committed slide count (wraps)
//   busy                     fetch in progress (== rnd_req)
//   miss                     one-cycle pulse: boundary with no shadow ready
module slide_sequencer
    import torso_pkg::*;
#(
    parameter int COORD_W     = DEF_COORD_W,
    parameter int TONE_FRAMES = 20,
    parameter int SLIDE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic               sec_pre,
    input  logic               sec_tick,
    output logic               rnd_req,
    input  logic               rnd_ack,
    input  logic [COORD_W-1:0] rnd_data,
    output logic [COORD_W-1:0] rect_x0,
    output logic [COORD_W-1:0] rect_y0,
    output logic [COORD_W-1:0] rect_x1,
    output logic [COORD_W-1:0] rect_y1,
    output logic               tone_en,
    output logic [SLIDE_W-1:0] slide_cnt,
    output logic               busy,
    output logic               miss
);

    seq_state_e         state_q, state_d;
    logic               pre_v, tick_v;
    logic               fetch_start, fetch_done, commit, miss_d;
    logic [COORD_W-1:0] sx0, sy0, sx1, sy1;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [SLIDE_W-1:0] slide_q;
    logic               miss_q;

    assign pre_v  = sec_pre & enable;
    assign tick_v = sec_tick & enable;

    rect_fetch #(.COORD_W(COORD_W)) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .start_i    (fetch_start),
        .rnd_req_o  (rnd_req),
        .rnd_ack_i  (rnd_ack),
        .rnd_data_i (rnd_data),
        .done_o     (fetch_done),
        .sx0_o      (sx0),
        .sy0_o      (sy0),
        .sx1_o      (sx1),
        .sy1_o      (sy1)
    );

    always_comb begin
        state_d     = state_q;
        fetch_start = 1'b0;
        commit      = 1'b0;
        miss_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_v) miss_d = 1'b1;
                if (pre_v) begin
                    state_d     = ST_FETCH;
                    fetch_start = 1'b1;
                end
            end
            ST_FETCH: begin
                // a fetch runs to completion even with enable low
                if (tick_v) miss_d = 1'b1;
                if (fetch_done) state_d = ST_READY;
            end
            ST_READY: begin
                if (tick_v) begin
                    commit = 1'b1;
                    if (pre_v) begin
                        state_d     = ST_FETCH;
                        fetch_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            slide_q <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            if (commit) begin
                x0_q    <= sx0;
                y0_q    <= sy0;
                x1_q    <= sx1;
                y1_q    <= sy1;
                slide_q <= slide_q + 1'b1;
            end
        end
    end

`ifdef SLIDE_SEQ_TONE_EN
    localparam logic [5:0] TONE_LOAD = 6'(TONE_FRAMES);

    logic [5:0] tone_q, tone_d;

    // commit wins over a same-cycle frame_tick, so that tick is not counted
    always_comb begin
        tone_d = tone_q;
        if (commit)
            tone_d = TONE_LOAD;
        else if (frame_tick && (tone_q != 6'd0))
            tone_d = tone_q - 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tone_q <= '0;
        else     tone_q <= tone_d;
    end

    assign tone_en = (tone_q != 6'd0);
`else
    logic unused_tone;
    assign unused_tone = frame_tick ^ (TONE_FRAMES != 0);
    assign tone_en     = 1'b0;
`endif

    assign rect_x0   = x0_q;
    assign rect_y0   = y0_q;
    assign rect_x1   = x1_q;
    assign rect_y1   = y1_q;
    assign slide_cnt = slide_q;
    assign busy      = rnd_req;
    assign miss      = miss_q;

endmodule

// File: tb/tb_slide_sequencer.sv
module tb_slide_sequencer;

    typedef struct {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] x1;
        logic [9:0] y1;
    } rect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       frame_tick = 1'b0;
    logic       sec_pre = 1'b0;
    logic       sec_tick = 1'b0;
    logic       rnd_ack = 1'b0;
    logic [9:0] rnd_data = '0;

    logic       rnd_req, tone_en, busy, miss;
    logic [9:0] rect_x0, rect_y0, rect_x1, rect_y1;
    logic [7:0] slide_cnt;

    logic       rnd_req2, tone_en2, busy2, miss2;
    logic [9:0] r2_x0, r2_y0, r2_x1, r2_y1;
    logic [1:0] slide_cnt2;

    int    checks = 0;
    int    errors = 0;
    rect_t exp_q[$];
    rect_t last_r = '{10'd0, 10'd0, 10'd0, 10'd0};
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    slide_sequencer #(.COORD_W(10), .TONE_FRAMES(20), .SLIDE_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
        .sec_pre(sec_pre), .sec_tick(sec_tick),
        .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd_data(rnd_data),
        .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_x1(rect_x1), .rect_y1(rect_y1),
        .tone_en(tone_en), .slide_cnt(slide_cnt), .busy(busy), .miss(miss)
    );

    // narrow slide counter instance sharing the same stimulus (wrap check)
    slide_sequencer #(.COORD_W(10), .TONE_FRAMES(20), .SLIDE_W(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
        .sec_pre(sec_pre), .sec_tick(sec_tick),
        .rnd_req(rnd_req2), .rnd_ack(rnd_ack), .rnd_data(rnd_data),
        .rect_x0(r2_x0), .rect_y0(r2_y0), .rect_x1(r2_x1), .rect_y1(r2_y1),
        .tone_en(tone_en2), .slide_cnt(slide_cnt2), .busy(busy2), .miss(miss2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pre();
        sec_pre = 1'b1;
        step();
        sec_pre = 1'b0;
        checks++;
        if (rnd_req !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL req_rise: rnd_req=%b busy=%b, want 1/1", rnd_req, busy); end
    endtask

    // drives four back-to-back acks and pushes the ordered rectangle
    task automatic feed(input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input logic [9:0] d);
        logic [9:0] w[4];
        rect_t e;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rnd_req !== 1'b1)
                begin errors++; $display("FAIL req_hold word %0d: rnd_req=%b, want 1", i, rnd_req); end
            rnd_ack  = 1'b1;
            rnd_data = w[i];
            step();
        end
        rnd_ack = 1'b0;
        checks++;
        if (rnd_req !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL req_fall: rnd_req=%b busy=%b, want 0/0", rnd_req, busy); end
        e.x0 = (a < c) ? a : c;
        e.x1 = (a < c) ? c : a;
        e.y0 = (b < d) ? b : d;
        e.y1 = (b < d) ? d : b;
        exp_q.push_back(e);
    endtask

    task automatic tick_commit(input string name, input logic with_pre, input logic with_frame);
        rect_t e;
        sec_tick   = 1'b1;
        sec_pre    = with_pre;
        frame_tick = with_frame;
        step();
        sec_tick   = 1'b0;
        sec_pre    = 1'b0;
        frame_tick = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s: scoreboard empty at commit", name);
            return;
        end
        e = exp_q.pop_front();
        exp_cnt++;
        last_r = e;
        if (rect_x0 !== e.x0 || rect_y0 !== e.y0 || rect_x1 !== e.x1 || rect_y1 !== e.y1)
            begin errors++; $display("FAIL %s rect: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                name, rect_x0, rect_y0, rect_x1, rect_y1, e.x0, e.y0, e.x1, e.y1); end
        checks++;
        if (slide_cnt !== exp_cnt)
            begin errors++; $display("FAIL %s slide_cnt: got %0d want %0d", name, slide_cnt, exp_cnt); end
        checks++;
        if (slide_cnt2 !== exp_cnt[1:0])
            begin errors++; $display("FAIL %s slide_cnt2: got %0d want %0d", name, slide_cnt2, exp_cnt[1:0]); end
        checks++;
        if (miss !== 1'b0)
            begin errors++; $display("FAIL %s miss: got %b want 0", name, miss); end
        checks++;
`ifdef SLIDE_SEQ_TONE_EN
        if (tone_en !== 1'b1)
            begin errors++; $display("FAIL %s tone_en: got %b want 1", name, tone_en); end
`else
        if (tone_en !== 1'b0)
            begin errors++; $display("FAIL %s tone_en: got %b want 0", name, tone_en); end
`endif
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic check_tone(input string name, input logic want_on);
        logic w;
`ifdef SLIDE_SEQ_TONE_EN
        w = want_on;
`else
        w = 1'b0;
`endif
        checks++;
        if (tone_en !== w)
            begin errors++; $display("FAIL %s: tone_en=%b want %b", name, tone_en, w); end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (rnd_req !== 0 || busy !== 0 || miss !== 0 || tone_en !== 0 || slide_cnt !== 0 ||
            rect_x0 !== 0 || rect_y0 !== 0 || rect_x1 !== 0 || rect_y1 !== 0)
            begin errors++; $display("FAIL reset_state: req=%b busy=%b miss=%b tone=%b cnt=%0d", rnd_req, busy, miss, tone_en, slide_cnt); end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (rnd_req !== 1'b0)
            begin errors++; $display("FAIL reset_idle_req: rnd_req=%b want 0", rnd_req); end
    endtask

    task automatic test_commit();
        rect_t e;
        pulse_pre();
        feed(10'd300, 10'd200, 10'd100, 10'd50);
        e = exp_q[0];
        checks++;
        if (e.x0 !== 10'd100 || e.y0 !== 10'd50 || e.x1 !== 10'd300 || e.y1 !== 10'd200)
            begin errors++; $display("FAIL model_order: (%0d,%0d,%0d,%0d) want (100,50,300,200)", e.x0, e.y0, e.x1, e.y1); end
        step();
        tick_commit("commit_basic", 1'b0, 1'b0);
        step();
        checks++;
        if (miss !== 1'b0 || rnd_req !== 1'b0)
            begin errors++; $display("FAIL post_commit_idle: miss=%b req=%b want 0/0", miss, rnd_req); end
    endtask

    task automatic test_tone();
        frames(19);
        check_tone("tone_after_19", 1'b1);
        frames(1);
        check_tone("tone_after_20", 1'b0);
        // second commit arrives at the 10th frame and coincides with a frame_tick
        pulse_pre();
        feed(10'd7, 10'd7, 10'd7, 10'd7);
        tick_commit("commit_tone1", 1'b0, 1'b0);
        frames(9);
        pulse_pre();
        feed(10'd512, 10'd1, 10'd3, 10'd1023);
        tick_commit("commit_tone_retrig", 1'b0, 1'b1);
        frames(19);
        check_tone("retrig_after_19", 1'b1);
        frames(1);
        check_tone("retrig_after_20", 1'b0);
    endtask

    task automatic test_miss();
        // disabled boundary is ignored entirely
        enable   = 1'b0;
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        enable   = 1'b1;
        checks++;
        if (miss !== 1'b0 || slide_cnt !== exp_cnt)
            begin errors++; $display("FAIL disabled_tick: miss=%b cnt=%0d want 0/%0d", miss, slide_cnt, exp_cnt); end
        pulse_pre();
        step();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        checks++;
        if (miss !== 1'b1)
            begin errors++; $display("FAIL miss_pulse: miss=%b want 1", miss); end
        checks++;
        if (slide_cnt !== exp_cnt || rect_x0 !== last_r.x0 || rect_y0 !== last_r.y0 ||
            rect_x1 !== last_r.x1 || rect_y1 !== last_r.y1)
            begin errors++; $display("FAIL miss_hold: cnt=%0d x0=%0d want cnt=%0d x0=%0d", slide_cnt, rect_x0, exp_cnt, last_r.x0); end
        step();
        checks++;
        if (miss !== 1'b0 || rnd_req !== 1'b1)
            begin errors++; $display("FAIL miss_one_cycle: miss=%b req=%b want 0/1", miss, rnd_req); end
        feed(10'd0, 10'd999, 10'd999, 10'd0);
        step();
        tick_commit("commit_after_miss", 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            pulse_pre();
            feed(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
            tick_commit($sformatf("wrap_commit_%0d", k), 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_back_to_back();
        pulse_pre();
        feed(10'd40, 10'd30, 10'd20, 10'd10);
        tick_commit("b2b_commit", 1'b1, 1'b0);
        checks++;
        if (rnd_req !== 1'b1)
            begin errors++; $display("FAIL b2b_req: rnd_req=%b want 1", rnd_req); end
        feed(10'd5, 10'd6, 10'd5, 10'd6);
        tick_commit("b2b_second", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        pulse_pre();
        rnd_ack  = 1'b1;
        rnd_data = 10'd77;
        step();
        step();
        rnd_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rnd_req !== 0 || busy !== 0 || miss !== 0 || tone_en !== 0 || slide_cnt !== 0 ||
            rect_x0 !== 0 || rect_y0 !== 0 || rect_x1 !== 0 || rect_y1 !== 0 || slide_cnt2 !== 0)
            begin errors++; $display("FAIL reset_mid: req=%b cnt=%0d x0=%0d x1=%0d want all 0", rnd_req, slide_cnt, rect_x0, rect_x1); end
        exp_cnt = 8'd0;
        last_r  = '{10'd0, 10'd0, 10'd0, 10'd0};
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        checks++;
        if (rnd_req !== 1'b0)
            begin errors++; $display("FAIL reset_mid_noreq: rnd_req=%b want 0", rnd_req); end
        // fresh fetch after reset starts at word 0
        pulse_pre();
        feed(10'd9, 10'd8, 10'd1, 10'd2);
        tick_commit("commit_after_reset", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_commit();
        test_tone();
        test_miss();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slide_sequencer.md
# slide_sequencer

Per-second slide controller for the rectangle display. It consumes the one-second pre-warning and boundary pulses from the frame-based second timer. On the pre-warning it fetches four random coordinates from the random source over a req/ack handshake, then orders them into a shadow rectangle. It commits the rectangle to the renderer exactly on the second boundary and gates the beep tone for a fixed number of frames after each commit.

## Interface
- COORD_W, 10, width of one coordinate word
- TONE_FRAMES, 20, frames tone_en stays high after a commit (1..63)
- SLIDE_W, 8, width of slide counter
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when low, sec_pre/sec_tick are ignored
- frame_tick  in  1  one-cycle pulse per frame end
- sec_pre  in  1  one-cycle pulse ~1 frame before the second boundary
- sec_tick  in  1  one-cycle pulse at the second boundary
- rnd_req  out  1  request for a random word
- rnd_ack  in  1  rnd_data valid this cycle
- rnd_data  in  COORD_W  random coordinate word
- rect_x0, rect_y0, rect_x1, rect_y1  out  COORD_W each  active rectangle, x0<=x1, y0<=y1
- tone_en  out  1  beep gate
- slide_cnt  out  SLIDE_W  committed slide count
- busy  out  1  fetch in progress
- miss  out  1  one-cycle pulse: boundary arrived with no shadow ready

## Operation
- States: IDLE, FETCH, READY.
- IDLE: sec_pre & enable -> FETCH, word index = 0.
- FETCH: rnd_req = 1. Each cycle with rnd_ack captures rnd_data into slot index (0:xa, 1:ya, 2:xb, 3:yb) and increments the index. The 4th capture -> READY.
- Shadow ordering on entry to READY: sx0=min(xa,xb), sx1=max(xa,xb), same for y. Equal values are allowed.
- READY: sec_tick & enable -> commit: active rect <= shadow, slide_cnt += 1 (wraps modulo 2^SLIDE_W), tone counter loads TONE_FRAMES, next state IDLE.
- sec_pre & sec_tick in the same cycle in READY: commit, then go directly to FETCH (index 0).
- sec_tick & enable in IDLE or FETCH: no commit, rectangle and slide_cnt unchanged, miss pulses. FETCH continues. The next sec_tick commits.
- sec_pre in FETCH or READY: ignored.
- enable low: fetch in progress still completes to READY. Tone counting continues.
- Tone counter: decrements on each frame_tick while nonzero. tone_en = (counter != 0). A commit while tone is active reloads the counter.

## Timing
- Reset values: state IDLE, rect_* = 0, tone_en = 0, slide_cnt = 0, rnd_req = 0, busy = 0, miss = 0, index = 0, shadow = 0.
- rnd_req rises the cycle after sec_pre is sampled. It stays high through all four words and falls the cycle after the 4th ack. busy equals rnd_req.
- rnd_data is sampled on the same edge as rnd_ack. Back-to-back acks give a 4-cycle fetch minimum.
- rect_*, slide_cnt and tone_en update the cycle after sec_tick is sampled.
- miss is registered and is high exactly one cycle, the cycle after sec_tick.
- tone_en falls the cycle after the TONE_FRAMES-th frame_tick following the commit. A frame_tick in the commit cycle itself is not counted.
- An asynchronous reset mid-fetch discards the partial words. The source must tolerate an abandoned request.

## Configuration
- SLIDE_SEQ_TONE_EN defined: the tone counter and tone_en behave as above.
- SLIDE_SEQ_TONE_EN undefined: tone_en is tied to 0, the counter is not built, and TONE_FRAMES is unused.

## Structure
- Shared package torso_pkg holds:
  - the sequencer state enum (IDLE/FETCH/READY);
  - the default COORD_W;
  - the coordinate-slot index constants.
- One sub-module, rect_fetch: it owns the FETCH handshake, the 4-slot capture and the min/max ordering, and presents shadow rectangle plus done. slide_sequencer keeps the FSM, commit, tone and slide counter.

## Test plan
- Reset asserted mid-fetch -> all outputs 0 asynchronously. After release there is no rnd_req until sec_pre.
- sec_pre; acks on 4 consecutive cycles with data 300,200,100,50; then sec_tick -> next cycle rect=(100,50,300,200), slide_cnt=1, tone_en=1, miss=0.
- TONE_FRAMES=20: after the commit, 20 frame_ticks -> tone_en low one cycle after the 20th. Commit again at the 10th frame_tick -> 20 more are needed.
- sec_pre, ack withheld, sec_tick -> miss=1 for one cycle, rect and slide_cnt unchanged. Complete 4 acks, next sec_tick -> commit and slide_cnt increments.
- SLIDE_W=2: four successful commits -> slide_cnt sequence 1,2,3,0.
- In READY, sec_pre and sec_tick in the same cycle -> commit next cycle and rnd_req=1 in that same cycle.
